// File: rtl/wimax_bits_pkg.sv
// wimax_bits_pkg: bit-order constants shared by the OFDM bit packer and unpacker.
package wimax_bits_pkg;
    localparam bit BIT_MSB_FIRST = 1'b1;
    localparam bit BIT_LSB_FIRST = 1'b0;
endpackage

// File: rtl/bit_unpacker_oreg.sv
// bit_unpacker_oreg: one-entry valid/ready output register; load has priority over drain.
module bit_unpacker_oreg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        valid_d = load_i ? 1'b1 : (ready_i ? 1'b0 : valid_q);
        data_d  = load_i ? data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/bit_unpacker.sv
// bit_unpacker: serial-to-parallel unpacker, one bit per beat into W-bit words,
// flushing a zero-padded partial word on in_last.
module bit_unpacker
    import wimax_bits_pkg::*;
#(
    parameter int W         = 8,
    parameter bit MSB_FIRST = BIT_MSB_FIRST
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_bit,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(W+1)-1:0] out_count,
    output logic                   out_last
);
    localparam int FW = $clog2(W);
    localparam int CW = $clog2(W+1);
    localparam int PW = W + CW + 1;

    logic [FW-1:0] fill_q, fill_d, pos;
    logic [W-1:0]  asm_q, asm_d, word;
    logic          complete, accept, load;
    logic [PW-1:0] payload;

    // The assembly register is cleared on every completion, so unwritten positions are already 0.
    always_comb begin
        pos      = (MSB_FIRST == BIT_MSB_FIRST) ? FW'(W-1) - fill_q : fill_q;
        complete = (fill_q == FW'(W-1)) || in_last;
        in_ready = !(complete && out_valid && !out_ready);
        accept   = in_valid && in_ready;
        load     = accept && complete;
        word     = asm_q | (W'(in_bit) << pos);
        fill_d   = !accept ? fill_q : (complete ? '0 : fill_q + 1'b1);
        asm_d    = !accept ? asm_q : (complete ? '0 : word);
        payload  = {in_last, CW'(fill_q) + CW'(1), word};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
            asm_q  <= '0;
        end else begin
            fill_q <= fill_d;
            asm_q  <= asm_d;
        end
    end

    logic [PW-1:0] out_payload;

    bit_unpacker_oreg #(.DW(PW)) u_oreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .data_i  (payload),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .data_o  (out_payload)
    );

    assign {out_last, out_count, out_data} = out_payload;
endmodule

// File: tb/tb_bit_unpacker.sv
// tb_bit_unpacker: directed checks of bit_unpacker in three configurations.
module tb_bit_unpacker;
    import wimax_bits_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic       a_in_valid = 0, a_in_bit = 0, a_in_last = 0, a_out_ready = 1;
    logic       a_in_ready, a_out_valid, a_out_last;
    logic [3:0] a_out_data;
    logic [2:0] a_out_count;

    logic       b_in_valid = 0, b_in_bit = 0, b_in_last = 0, b_out_ready = 1;
    logic       b_in_ready, b_out_valid, b_out_last;
    logic [3:0] b_out_data;
    logic [2:0] b_out_count;

    logic       c_in_valid = 0, c_in_bit = 0, c_in_last = 0, c_out_ready = 1;
    logic       c_in_ready, c_out_valid, c_out_last;
    logic [7:0] c_out_data;
    logic [3:0] c_out_count;

    bit_unpacker #(.W(4), .MSB_FIRST(BIT_MSB_FIRST)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_bit(a_in_bit), .in_last(a_in_last), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_count(a_out_count),
        .out_last(a_out_last)
    );

    bit_unpacker #(.W(4), .MSB_FIRST(BIT_LSB_FIRST)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_bit(b_in_bit), .in_last(b_in_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_count(b_out_count),
        .out_last(b_out_last)
    );

    bit_unpacker #(.W(8), .MSB_FIRST(BIT_LSB_FIRST)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_bit(c_in_bit), .in_last(c_in_last), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_count(c_out_count),
        .out_last(c_out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_beat(input logic b, input logic l);
        a_in_valid = 1; a_in_bit = b; a_in_last = l;
        #1 chk("a_in_ready", 32'(a_in_ready), 1);
        @(posedge clk); #1;
        a_in_valid = 0; a_in_last = 0;
    endtask

    task automatic b_beat(input logic b);
        b_in_valid = 1; b_in_bit = b; b_in_last = 0;
        #1 chk("b_in_ready", 32'(b_in_ready), 1);
        @(posedge clk); #1;
        b_in_valid = 0;
    endtask

    task automatic a_word(input logic [3:0] d, input logic [2:0] n, input logic l, input string tag);
        chk({tag, "_valid"}, 32'(a_out_valid), 1);
        chk({tag, "_data"}, 32'(a_out_data), 32'(d));
        chk({tag, "_count"}, 32'(a_out_count), 32'(n));
        chk({tag, "_last"}, 32'(a_out_last), 32'(l));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 0;
        #20 rst_n = 1;
        idle(1);
        chk("rst_valid", 32'(a_out_valid), 0);
        chk("rst_data", 32'(a_out_data), 0);
        chk("rst_count", 32'(a_out_count), 0);
        chk("rst_last", 32'(a_out_last), 0);
        chk("rst_in_ready", 32'(a_in_ready), 1);
        chk("rst_c_valid", 32'(c_out_valid), 0);

        // MSB-first full word and one-cycle latency
        a_beat(0, 0); a_beat(1, 0); a_beat(0, 0);
        chk("t1_no_early_valid", 32'(a_out_valid), 0);
        a_beat(1, 0);
        a_word(4'b0101, 4, 0, "t1");
        idle(1);
        chk("t1_drained", 32'(a_out_valid), 0);

        // partial word flushed by in_last, then next word starts from fill 0
        a_beat(1, 0); a_beat(1, 0); a_beat(0, 1);
        a_word(4'b1100, 3, 1, "t3");
        a_beat(1, 0); a_beat(0, 0); a_beat(1, 0); a_beat(1, 0);
        a_word(4'b1011, 4, 0, "t3_next");

        // in_last exactly at the last position yields a full word
        a_beat(0, 0); a_beat(0, 0); a_beat(0, 0); a_beat(1, 1);
        a_word(4'b0001, 4, 1, "tfull_last");
        idle(1);

        // backpressure: word 1 held, bits 5..7 accepted, bit 8 stalls
        a_out_ready = 0;
        a_beat(1, 0); a_beat(0, 0); a_beat(0, 0); a_beat(0, 0);
        a_word(4'b1000, 4, 0, "bp_w1");
        a_beat(0, 0); a_beat(1, 0); a_beat(1, 0);
        a_word(4'b1000, 4, 0, "bp_w1_held");
        a_in_valid = 1; a_in_bit = 1; a_in_last = 0;
        #1 chk("bp_stall", 32'(a_in_ready), 0);
        @(posedge clk); #1;
        chk("bp_stall2", 32'(a_in_ready), 0);
        a_word(4'b1000, 4, 0, "bp_w1_still");
        a_out_ready = 1;
        #1 chk("bp_release", 32'(a_in_ready), 1);
        @(posedge clk); #1;
        a_in_valid = 0;
        a_word(4'b0111, 4, 0, "bp_w2");
        idle(1);
        chk("bp_drained", 32'(a_out_valid), 0);

        // asynchronous reset mid-word with a held word present
        a_out_ready = 0;
        a_beat(1, 0); a_beat(1, 0); a_beat(1, 0); a_beat(1, 0);
        a_word(4'b1111, 4, 0, "rs_held");
        a_beat(1, 0); a_beat(1, 0);
        #2 rst_n = 0;
        #1;
        chk("rs_valid", 32'(a_out_valid), 0);
        chk("rs_data", 32'(a_out_data), 0);
        chk("rs_count", 32'(a_out_count), 0);
        chk("rs_in_ready", 32'(a_in_ready), 1);
        #1 rst_n = 1;
        a_out_ready = 1;
        idle(1);
        a_beat(1, 0); a_beat(0, 0); a_beat(0, 0); a_beat(1, 0);
        a_word(4'b1001, 4, 0, "rs_after");

        // LSB-first and back-to-back words
        b_beat(0); b_beat(1); b_beat(0); b_beat(1);
        chk("b_w0_data", 32'(b_out_data), 32'hA);
        chk("b_w0_valid", 32'(b_out_valid), 1);
        b_beat(1); b_beat(1); b_beat(1); b_beat(1);
        chk("b_w1_data", 32'(b_out_data), 32'hF);
        chk("b_w1_valid", 32'(b_out_valid), 1);
        b_beat(0); b_beat(0); b_beat(0); b_beat(0);
        chk("b_w2_data", 32'(b_out_data), 32'h0);
        chk("b_w2_count", 32'(b_out_count), 4);
        chk("b_w2_valid", 32'(b_out_valid), 1);

        // single-bit frame on W=8, LSB-first
        c_in_valid = 1; c_in_bit = 1; c_in_last = 1;
        #1 chk("c_in_ready", 32'(c_in_ready), 1);
        @(posedge clk); #1;
        c_in_valid = 0; c_in_last = 0;
        chk("c_valid", 32'(c_out_valid), 1);
        chk("c_data", 32'(c_out_data), 32'h01);
        chk("c_count", 32'(c_out_count), 1);
        chk("c_last", 32'(c_out_last), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bit_unpacker.md
# bit_unpacker

Serial-to-parallel bit unpacker for the OFDM bit path. Receives one bit per accepted beat and assembles `W`-bit words, placing the first-received bit at the MSB or the LSB depending on `MSB_FIRST`. A frame-end marker flushes a partial word. It is the receive-side counterpart of the bit packer/serializer, and its parameters must match that block's bit order. One output register with valid/ready backpressure decouples the bit stream from the word consumer.

## Interface
- `W`, 8: output word width, ≥2.
- `MSB_FIRST`, 1: 1 means the first bit lands at `out_data[W-1]`; 0 means it lands at `out_data[0]`.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: `in_bit` and `in_last` are valid.
- `in_ready` output 1: unpacker accepts the beat this cycle.
- `in_bit` input 1: serial data bit.
- `in_last` input 1: this bit is the final bit of the frame; the word is flushed.
- `out_valid` output 1: `out_data`, `out_count` and `out_last` are valid.
- `out_ready` input 1: consumer accepts the word.
- `out_data` output W: assembled word, zero-padded when partial.
- `out_count` output $clog2(W+1): number of valid bits in `out_data` (1..W).
- `out_last` output 1: word closed by `in_last`.

## Operation
- Accept a beat when `in_valid && in_ready`.
- Fill counter `fill` runs 0..W-1. A beat with index k = `fill` writes shift-register position `W-1-k` if `MSB_FIRST`, else position k.
- A word completes when an accepted beat has `fill == W-1` or `in_last == 1`.
  - On completion, load the output register with the assembly bits, with positions not yet written forced to 0.
  - Set `out_count = fill+1` and `out_last = in_last`, then reset `fill` and the assembly register to 0.
  - If `in_last` arrives exactly at `fill == W-1`, report a full word with `out_count = W` and `out_last = 1`.
- A non-completing beat always has `in_ready = 1`, even while the output register is held.
- `in_ready = 0` only when the pending beat would complete a word, `out_valid = 1` and `out_ready = 0`. This is combinational from `fill`, `in_last`, `out_valid` and `out_ready`, and does not depend on `in_valid`.
- The output register holds its value while `out_valid && !out_ready`.
- If the output is drained and a new word completes in the same cycle, the new word loads with no bubble and `out_valid` stays 1.
- Reset mid-word discards the partial word, and nothing is emitted for it.
- No FSM beyond the fill counter and the output valid flag.

## Timing
- Reset values:
  - `out_valid = 0`, `out_data = 0`, `out_count = 0`, `out_last = 0`.
  - `fill = 0` and assembly register = 0.
  - `in_ready = 1` immediately, since `out_valid = 0`.
- Latency: `out_valid` rises on the clock edge that accepts the completing bit, so it is visible the cycle after that bit was presented.
- Throughput: one bit per cycle sustained. A word every W cycles when the consumer is always ready.
- Outputs are registered except `in_ready`.

## Structure
- Shared package `wimax_bits_pkg` holds the bit-order constants `BIT_MSB_FIRST=1` and `BIT_LSB_FIRST=0`. The same constants parameterize the matching packer, so the pair cannot disagree.
- Sub-module `bit_unpacker_oreg`: one-entry valid/ready output register, reusable by the packer.
- The assembly register and fill counter stay in the top module.

## Test plan
- W=4, MSB_FIRST=1, bits 0,1,0,1, none with in_last, out_ready=1 -> one word `out_data=4'b0101`, `out_count=4`, `out_last=0`, with `out_valid` high exactly one cycle after the 4th bit.
- W=4, MSB_FIRST=0, same bits -> `out_data=4'b1010`. Then 8 back-to-back bits 1,1,1,1,0,0,0,0 -> words `4'b1111` then `4'b0000` with no input stall.
- W=4, MSB_FIRST=1, bits 1,1,0 with in_last on the 3rd bit -> `out_data=4'b1100`, `out_count=3`, `out_last=1`. The next bit starts at `fill=0`.
- W=4, out_ready=0 while bits stream -> the 4th bit is accepted and word 1 is held. Bits 5–7 are accepted. The 8th bit sees `in_ready=0` until out_ready rises. At the rising cycle word 1 drains and word 2 loads in the same edge, and no bits are lost or duplicated.
- rst_n pulsed low asynchronously mid-clock after 2 of 4 bits -> all outputs 0 immediately. The next 4 bits 1,0,0,1 give `4'b1001` with no trace of the old bits.
- in_last on a single bit (1), W=8, MSB_FIRST=0 -> `out_data=8'h01`, `out_count=1`, `out_last=1`.
